mixcol_seq: RTL and testbench
=============================

Name: mixcol_seq

Overview:
- Sequential, parametrised successor to the combinational MixColumns stage of the AES datapath.
- Computes forward MixColumns (encrypt) or InvMixColumns (decrypt) on a 128-bit AES state.
- Processes COLS_PER_CYCLE columns per clock under a start/finished handshake. This trades area for latency.
- Sits between the ShiftRows and AddRoundKey stages and is driven by the round controller.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per clock. Legal values are 1, 2 and 4; any other value is an elaboration error.
- NUM_PASSES, 4/COLS_PER_CYCLE, derived localparam (not overridable); number of CALC cycles.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- mixcol_enable  in  1  start request, sampled on a clk rising edge.
- inverse  in  1  0 = forward MixColumns, 1 = InvMixColumns; sampled together with mixcol_enable.
- olddata  in  128  input state, row-major: byte (r,c) at bits [127-8*(4r+c) -: 8].
- newdata  out  128  result state, same packing as olddata.
- mixcol_finished  out  1  one-cycle completion pulse.
- busy  out  1  high while an operation is in progress (CALC).

Behaviour:
- Reset (n_rst low, asynchronous):
  - state = IDLE; newdata = 0; mixcol_finished = 0; busy = 0.
  - Column counter, working register and latched mode are all cleared.
- States: IDLE, CALC, DONE.
- IDLE:
  - On an edge with mixcol_enable=1: latch olddata into the working register, latch inverse, clear col_cnt, go to CALC.
  - Otherwise stay in IDLE.
- CALC (busy=1):
  - Each edge transforms columns col_cnt .. col_cnt+COLS_PER_CYCLE-1 of the working register in place.
  - col_cnt advances by COLS_PER_CYCLE.
  - On the edge that processes column 3: copy the full working register to newdata, go to DONE.
- DONE (mixcol_finished=1, busy=0), lasts exactly one cycle:
  - mixcol_enable=1 on this edge starts a new operation (straight to CALC, back-to-back).
  - Otherwise go to IDLE.
- Latency:
  - mixcol_finished goes high NUM_PASSES cycles after the edge that sampled mixcol_enable: 4 cycles for COLS_PER_CYCLE=1, 1 cycle for COLS_PER_CYCLE=4.
  - Throughput is one operation per NUM_PASSES+1 cycles.
- newdata update rules:
  - Updated atomically, only on the completion edge; never partially updated.
  - Holds its value until the next completion or reset.
- mixcol_enable while in CALC: ignored. No queuing; the in-flight operation is unaffected.
- olddata and inverse changes after acceptance: no effect on the in-flight operation (both are latched).
- Column math, per column a0..a3 (rows 0..3), arithmetic in GF(2^8) with polynomial 0x11B:
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00).
  - Forward, matrix rows [2 3 1 1] rotated per row: b0 = 2a0^3a1^a2^a3, and so on.
  - Inverse, matrix rows [14 11 13 9] rotated per row.
  - 9, 11, 13 and 14 are built from repeated xtime and XOR only. No lookup tables, no multipliers.
- Reset asserted mid-operation: abort immediately, all outputs go to their reset values, and no finished pulse follows.
- No enable pending after DONE: the block stays idle indefinitely, with newdata stable.

Test Plan:
- COLS_PER_CYCLE=1, inverse=0, olddata=128'hd4e0b81ebfb441275d52119830aef1e5, single-cycle enable:
  - busy high for 4 cycles, then mixcol_finished pulses for exactly 1 cycle.
  - newdata = 128'h04e0482866cbf8068119d326e59a7a4c.
- Same configuration, inverse=1, olddata=128'h04e0482866cbf8068119d326e59a7a4c:
  - newdata = 128'hd4e0b81ebfb441275d52119830aef1e5.
- COLS_PER_CYCLE=4 and =2, vector from the first scenario:
  - finished arrives 1 and 2 cycles after enable respectively; newdata is identical to the first scenario.
- Column vectors, in each case with the other three columns all 8'h01:
  - Column 0 = db,13,53,45 gives column 0 out = 8e,4d,a1,bc.
  - Column 0 = c6,c6,c6,c6 is unchanged.
  - All-01 columns stay 01 in both modes.
- Enable re-asserted during CALC with a different olddata:
  - Ignored; the first result is produced.
  - Enable held across DONE starts a back-to-back operation, giving a second finished exactly NUM_PASSES+1 cycles after the first.
- n_rst pulsed low in the 2nd CALC cycle:
  - newdata=0, busy=0, no finished pulse.
  - A fresh enable afterwards completes correctly with full latency.

Source files
------------

// File: rtl/mixcol_seq.sv
// -----------------------------------------------------------------------------
// mixcol_seq
//   Sequential AES MixColumns / InvMixColumns stage. An accepted 128-bit state
//   is transformed COLS_PER_CYCLE columns per clock in a working register and
//   the full result is published on newdata in one step when the last column
//   has been processed.
//
// Ports
//   clk             in   1    system clock, rising edge
//   n_rst           in   1    asynchronous active-low reset
//   mixcol_enable   in   1    start request (accepted in IDLE or DONE)
//   inverse         in   1    0 = MixColumns, 1 = InvMixColumns (latched on start)
//   olddata         in   128  input state, byte (r,c) at [127-8*(4r+c) -: 8]
//   newdata         out  128  result state, same packing
//   mixcol_finished out  1    one-cycle completion pulse (DONE)
//   busy            out  1    high while columns are being transformed (CALC)
// -----------------------------------------------------------------------------
module mixcol_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         mixcol_enable,
  input  logic         inverse,
  input  logic [127:0] olddata,
  output logic [127:0] newdata,
  output logic         mixcol_finished,
  output logic         busy
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mixcol_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam int NUM_PASSES = 4 / COLS_PER_CYCLE;
  // Column counter step and the counter value seen on the final pass.
  // With four columns per pass the step wraps to zero, which is harmless.
  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_CNT = 2'(COLS_PER_CYCLE * (NUM_PASSES - 1));

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic           w_accept;
  logic           w_last_pass;
  logic [127:0]   w_work_next;
  logic [127:0]   r_work;
  logic [127:0]   r_newdata;
  logic [1:0]     r_col_cnt;
  logic           r_inv;
  logic           r_busy;
  logic           r_finished;

  // GF(2^8) multiply by 2, reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // One column {a0,a1,a2,a3} (row 0 in the top byte) through the forward or
  // inverse matrix. Higher multiples come from chained xtime plus XOR.
  function automatic logic [31:0] mix_column(input logic [31:0] col, input logic inv);
    logic [7:0]  a  [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [31:0] res;
    int          r1, r2, r3;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
    end
    res = 32'h0000_0000;
    for (int r = 0; r < 4; r++) begin
      r1 = (r + 1) & 3;
      r2 = (r + 2) & 3;
      r3 = (r + 3) & 3;
      if (inv) begin
        // 14*a[r] ^ 11*a[r+1] ^ 13*a[r+2] ^ 9*a[r+3]
        res[31-8*r -: 8] = (x8[r]  ^ x4[r]  ^ x2[r])
                         ^ (x8[r1] ^ x2[r1] ^ a[r1])
                         ^ (x8[r2] ^ x4[r2] ^ a[r2])
                         ^ (x8[r3] ^ a[r3]);
      end else begin
        // 2*a[r] ^ 3*a[r+1] ^ a[r+2] ^ a[r+3]
        res[31-8*r -: 8] = x2[r] ^ (x2[r1] ^ a[r1]) ^ a[r2] ^ a[r3];
      end
    end
    return res;
  endfunction

  // Transform columns cnt .. cnt+COLS_PER_CYCLE-1 of the state, leave the rest.
  function automatic logic [127:0] calc_pass(input logic [127:0] st,
                                             input logic [1:0]   cnt,
                                             input logic         inv);
    logic [127:0] res;
    logic [31:0]  col;
    logic [31:0]  mixed;
    int           c;
    res = st;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      c = int'(cnt) + j;
      for (int r = 0; r < 4; r++) begin
        col[31-8*r -: 8] = st[127-8*(4*r+c) -: 8];
      end
      mixed = mix_column(col, inv);
      for (int r = 0; r < 4; r++) begin
        res[127-8*(4*r+c) -: 8] = mixed[31-8*r -: 8];
      end
    end
    return res;
  endfunction

  assign w_work_next = calc_pass(r_work, r_col_cnt, r_inv);
  assign w_last_pass = (r_col_cnt == LAST_CNT);

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and start acceptance (IDLE or DONE with enable).
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (mixcol_enable) begin
          w_next_state = CALC;
          w_accept     = 1'b1;
        end else begin
          w_next_state = IDLE;
        end
      end
      CALC: begin
        if (w_last_pass) begin
          w_next_state = DONE;
        end else begin
          w_next_state = CALC;
        end
      end
      DONE: begin
        if (mixcol_enable) begin
          w_next_state = CALC;
          w_accept     = 1'b1;
        end else begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Working register, counter, latched mode, result and status flags.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_work     <= 128'h0;
      r_newdata  <= 128'h0;
      r_col_cnt  <= 2'b00;
      r_inv      <= 1'b0;
      r_busy     <= 1'b0;
      r_finished <= 1'b0;
    end else begin
      r_busy     <= (w_next_state == CALC);
      r_finished <= (w_next_state == DONE);
      if (w_accept) begin
        r_work    <= olddata;
        r_inv     <= inverse;
        r_col_cnt <= 2'b00;
      end else if (r_state == CALC) begin
        r_work    <= w_work_next;
        r_col_cnt <= r_col_cnt + STEP;
        // Publish the whole state at once on the final pass only.
        if (w_last_pass) begin
          r_newdata <= w_work_next;
        end
      end
    end
  end

  assign newdata         = r_newdata;
  assign mixcol_finished = r_finished;
  assign busy            = r_busy;

endmodule

// File: tb/tb_mixcol_seq.sv
// -----------------------------------------------------------------------------
// tb_mixcol_seq
//   Drives one shared stimulus into three mixcol_seq instances
//   (COLS_PER_CYCLE = 1, 2, 4) and compares every cycle against a latency /
//   GF(2^8) matrix model, plus literal checks on known AES vectors.
// -----------------------------------------------------------------------------
module tb_mixcol_seq;

  localparam logic [127:0] V0    = 128'hd4e0b81ebfb441275d52119830aef1e5;
  localparam logic [127:0] V1    = 128'h04e0482866cbf8068119d326e59a7a4c;
  localparam logic [127:0] C_IN  = 128'hdb010101_13010101_53010101_45010101;
  localparam logic [127:0] C_OUT = 128'h8e010101_4d010101_a1010101_bc010101;
  localparam logic [127:0] C6    = 128'hc6010101_c6010101_c6010101_c6010101;
  localparam logic [127:0] ONES  = {16{8'h01}};

  logic         clk = 1'b0;
  logic         n_rst = 1'b1;
  logic         en = 1'b0;
  logic         inv = 1'b0;
  logic [127:0] od = 128'h0;
  logic [127:0] nd  [3];
  logic         fin [3];
  logic         bsy [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // model state
  int           m_left [3];
  logic         m_fin  [3];
  logic [127:0] m_res  [3];
  logic [127:0] m_nd   [3];

  // completion bookkeeping (written by the monitor branch only)
  int fin_last [3];
  int fin_prev [3];
  int fin_cnt  [3];

  always #5 clk = ~clk;

  mixcol_seq #(.COLS_PER_CYCLE(1)) u_c1 (
    .clk(clk), .n_rst(n_rst), .mixcol_enable(en), .inverse(inv), .olddata(od),
    .newdata(nd[0]), .mixcol_finished(fin[0]), .busy(bsy[0]));
  mixcol_seq #(.COLS_PER_CYCLE(2)) u_c2 (
    .clk(clk), .n_rst(n_rst), .mixcol_enable(en), .inverse(inv), .olddata(od),
    .newdata(nd[1]), .mixcol_finished(fin[1]), .busy(bsy[1]));
  mixcol_seq #(.COLS_PER_CYCLE(4)) u_c4 (
    .clk(clk), .n_rst(n_rst), .mixcol_enable(en), .inverse(inv), .olddata(od),
    .newdata(nd[2]), .mixcol_finished(fin[2]), .busy(bsy[2]));

  function automatic int np(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 2 : 1);
  endfunction

  // Generic GF(2^8) multiply (shift-and-add), polynomial 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] coef(input logic iv, input int d);
    logic [7:0] v;
    case (d)
      0: v = iv ? 8'd14 : 8'd2;
      1: v = iv ? 8'd11 : 8'd3;
      2: v = iv ? 8'd13 : 8'd1;
      default: v = iv ? 8'd9 : 8'd1;
    endcase
    return v;
  endfunction

  // Full-state matrix product: b(r,c) = XOR_i M[r][i] * a(i,c), M circulant.
  function automatic logic [127:0] mix_model(input logic [127:0] s, input logic iv);
    logic [127:0] o;
    logic [7:0]   acc;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int i = 0; i < 4; i++) begin
          acc = acc ^ gmul(coef(iv, (i - r + 4) % 4), s[127-8*(4*i+c) -: 8]);
        end
        o[127-8*(4*r+c) -: 8] = acc;
      end
    end
    return o;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model: an accepted request completes np(k) edges later.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < 3; k++) begin
        m_left[k] <= 0;
        m_fin[k]  <= 1'b0;
        m_res[k]  <= 128'h0;
        m_nd[k]   <= 128'h0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        m_fin[k] <= 1'b0;
        if (m_left[k] > 0) begin
          m_left[k] <= m_left[k] - 1;
          if (m_left[k] == 1) begin
            m_fin[k] <= 1'b1;
            m_nd[k]  <= m_res[k];
          end
        end else if (en) begin
          m_left[k] <= np(k);
          m_res[k]  <= mix_model(od, inv);
        end
      end
    end
  end

  // Start one operation; returns the edge number at which it is sampled.
  task automatic start_op(input logic [127:0] data, input logic iv, output int a);
    @(posedge clk); #1;
    en = 1'b1; od = data; inv = iv; a = cyc + 1;
    @(posedge clk); #1;
    en = 1'b0; od = {$urandom, $urandom, $urandom, $urandom}; inv = ~iv;
  endtask

  task automatic run_op(input string name, input logic [127:0] data, input logic iv,
                        input logic [127:0] exp);
    int a;
    start_op(data, iv, a);
    repeat (5) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_data_k%0d", name, k), nd[k], exp);
      chk($sformatf("%s_latency_k%0d", name, k), 128'(fin_last[k] - a), 128'(np(k)));
    end
  endtask

  initial begin
    int a;
    int snap [3];
    for (int k = 0; k < 3; k++) begin
      fin_last[k] = 0; fin_prev[k] = 0; fin_cnt[k] = 0;
    end
    #1 n_rst = 1'b0;

    fork
      forever begin
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("cyc%0d_busy_k%0d", cyc, k), 128'(bsy[k]), 128'(m_left[k] > 0));
          chk($sformatf("cyc%0d_fin_k%0d", cyc, k), 128'(fin[k]), 128'(m_fin[k]));
          chk($sformatf("cyc%0d_newdata_k%0d", cyc, k), nd[k], m_nd[k]);
          if (fin[k] === 1'b1) begin
            fin_prev[k] = fin_last[k];
            fin_last[k] = cyc;
            fin_cnt[k]++;
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_newdata_k%0d", k), nd[k], 128'h0);
      chk($sformatf("reset_busy_k%0d", k), 128'(bsy[k]), 128'h0);
      chk($sformatf("reset_fin_k%0d", k), 128'(fin[k]), 128'h0);
    end
    @(posedge clk); #1 n_rst = 1'b1;

    // pin the model on known vectors
    chk("model_fwd", mix_model(V0, 1'b0), V1);
    chk("model_inv", mix_model(V1, 1'b1), V0);
    chk("model_col", mix_model(C_IN, 1'b0), C_OUT);

    run_op("aes_fwd", V0, 1'b0, V1);
    run_op("aes_inv", V1, 1'b1, V0);
    run_op("col_fwd", C_IN, 1'b0, C_OUT);
    run_op("col_inv", C_OUT, 1'b1, C_IN);
    run_op("c6_fwd", C6, 1'b0, C6);
    run_op("c6_inv", C6, 1'b1, C6);
    run_op("ones_fwd", ONES, 1'b0, ONES);
    run_op("ones_inv", ONES, 1'b1, ONES);

    // Enable during CALC ignored, held into DONE -> back-to-back.
    @(posedge clk); #1;
    en = 1'b1; od = V0; inv = 1'b0; a = cyc + 1;
    @(posedge clk); #1;            // edge a sampled first request
    en = 1'b0; od = C6;
    @(posedge clk); #1;            // edge a+1
    en = 1'b1;
    repeat (3) @(posedge clk);     // edges a+2..a+4
    @(negedge clk);
    chk("busy_ignore_first_result", nd[0], V1);
    chk("busy_ignore_fin", 128'(fin[0]), 128'h1);
    @(posedge clk); #1;            // edge a+5 accepts second request
    en = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("b2b_second_result", nd[0], C6);
    chk("b2b_spacing", 128'(fin_last[0] - fin_prev[0]), 128'd5);

    // Reset in the second CALC cycle aborts the operation.
    repeat (2) @(posedge clk);
    start_op(V0, 1'b0, a);         // returns just after edge a
    @(posedge clk); #1 n_rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("abort_newdata_k%0d", k), nd[k], 128'h0);
      chk($sformatf("abort_busy_k%0d", k), 128'(bsy[k]), 128'h0);
      snap[k] = fin_cnt[k];
    end
    @(posedge clk); #1 n_rst = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("abort_no_fin_k%0d", k), 128'(fin_cnt[k]), 128'(snap[k]));
    end
    run_op("after_abort", V0, 1'b0, V1);

    // Randomized traffic, checked by the per-cycle monitor.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      en  = ($urandom_range(0, 2) == 0);
      inv = $urandom_range(0, 1) == 1;
      od  = {$urandom, $urandom, $urandom, $urandom};
    end
    @(posedge clk); #1 en = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
